// File: rtl/xor3_parity_scheduler_if.sv
// Request/result bundle between the requester ports and the shared XOR3 parity scheduler.
interface xor3_parity_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic                  parity;

  modport master (
    output req, data_in,
    input  gnt, busy, done, done_id, parity
  );

  modport slave (
    input  req, data_in,
    output gnt, busy, done, done_id, parity
  );
endinterface

// File: rtl/xor3_parity_scheduler.sv
// Round-robin share of one 3-input XOR fold engine; WIDTH/2 folds per word, result tagged with requester.
// Build option: define XOR3_ODD_PARITY_EN for odd parity (accumulator seeded with 1 at grant).
module xor3_parity_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 2
) (
  input logic                      clk_i,
  input logic                      rst_i,
  xor3_parity_scheduler_if.slave   bus
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(HALF + 1);

`ifdef XOR3_ODD_PARITY_EN
  localparam logic ACC_INIT = 1'b1;
`else
  localparam logic ACC_INIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic              acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              done_q, done_d;
  logic [IDW-1:0]    done_id_q, done_id_d;
  logic              parity_q, parity_d;

  logic              win_vld;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     cand;
  logic [WIDTH-1:0]  win_dat;
  logic              fold;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[PW-1:0];
  endfunction

  // Search upward from the pointer with wrap; first requester found wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    win_dat = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_add(ptr_q, k);
      if (!win_vld && bus.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
        win_dat = bus.data_in[cand*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    done_d    = 1'b0;
    done_id_d = '0;
    parity_d  = 1'b0;
    fold      = acc_q ^ sh_q[0] ^ sh_q[1];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (win_vld) begin
          gnt_d   = NREQ'(1) << win_idx;
          sh_d    = win_dat;
          acc_d   = ACC_INIT;
          cnt_d   = '0;
          id_d    = IDW'(win_idx);
          ptr_d   = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = fold;
        sh_d  = sh_q >> 2;
        cnt_d = cnt_q + CW'(1);
        // Last fold lands directly in the registered result outputs.
        if (cnt_q == CW'(HALF - 1)) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          done_id_d = id_q;
          parity_d  = fold;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      sh_q      <= '0;
      acc_q     <= 1'b0;
      cnt_q     <= '0;
      id_q      <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      parity_q  <= parity_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.parity  = parity_q;

endmodule
